rx_frame_collector: RTL and testbench

RX_FRAME_COLLECTOR -- requirements
Module: rx_frame_collector

---
 rtl/mac_pkg.sv | 22 ++
 rtl/rx_term_locator.sv | 36 +++
 rtl/rx_frame_collector.sv | 157 +++++++++++++++
 tb/tb_rx_frame_collector.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared 10G MAC receive constants: XGMII control codes, frame sizing and the
// collector state encoding.
package mac_pkg;

    localparam logic [7:0] MAC_IDLE_CODE     = 8'h07;
    localparam logic [7:0] MAC_START_CODE    = 8'hFB;
    localparam logic [7:0] MAC_TERM_CODE     = 8'hFD;
    localparam logic [7:0] MAC_PREAMBLE_CODE = 8'h55;
    localparam logic [7:0] MAC_SFD_CODE      = 8'hD5;

    localparam int MAC_MAX_FRAME_SIZE  = 1518;
    localparam int MAC_MAX_PACKET_SIZE = 1526;
    // START/TERM bytes plus one spare byte so the last partial word still fits
    localparam int MAC_BUF_BYTES       = MAC_MAX_PACKET_SIZE + 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DISCARD = 2'd2
    } rx_state_e;

endpackage

// File: rtl/rx_term_locator.sv
// Finds the lowest lane carrying a TERM control character and flags any other
// control character sitting below it.
module rx_term_locator
    import mac_pkg::*;
#(
    parameter int         DATA_WIDTH = 64,
    parameter int         CTRL_WIDTH = 8,
    parameter logic [7:0] TERM_CODE  = MAC_TERM_CODE
) (
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic [CTRL_WIDTH-1:0] i_rx_ctrl,
    output logic                  term_found,
    output logic [2:0]            term_lane,
    output logic                  bad_ctrl_found
);

    // Lowest-lane priority scan; lanes above the first TERM are not inspected
    always_comb begin
        term_found     = 1'b0;
        term_lane      = 3'd0;
        bad_ctrl_found = 1'b0;
        for (int l = 0; l < CTRL_WIDTH; l++) begin
            if (!term_found && i_rx_ctrl[l]) begin
                if (i_rx_data[l*8 +: 8] == TERM_CODE) begin
                    term_found = 1'b1;
                    term_lane  = 3'(l);
                end else begin
                    bad_ctrl_found = 1'b1;
                end
            end else begin
                term_found = term_found;
            end
        end
    end

endmodule

// File: rtl/rx_frame_collector.sv
// Collects 64-bit XGMII words between START and TERM into a byte buffer and
// publishes each complete frame with its length and a one-cycle valid pulse.
module rx_frame_collector
    import mac_pkg::*;
#(
    parameter int         DATA_WIDTH      = 64,
    parameter int         CTRL_WIDTH      = 8,
    parameter logic [7:0] IDLE_CODE       = MAC_IDLE_CODE,
    parameter logic [7:0] START_CODE      = MAC_START_CODE,
    parameter logic [7:0] TERM_CODE       = MAC_TERM_CODE,
    parameter int         MAX_PACKET_SIZE = MAC_MAX_PACKET_SIZE,
    localparam int        BUF_BYTES       = MAX_PACKET_SIZE + 3
) (
    input  logic                   clk,
    input  logic                   i_rst_n,
    input  logic [DATA_WIDTH-1:0]  i_rx_data,
    input  logic [CTRL_WIDTH-1:0]  i_rx_ctrl,
    output logic [BUF_BYTES*8-1:0] o_rx_array_data,
    output logic                   o_data_valid,
    output logic [10:0]            o_frame_len,
    output logic                   o_framing_error,
    output logic                   o_overflow_error
);

    localparam int                   BUF_W     = BUF_BYTES * 8;
    localparam logic [BUF_W-1:0]     IDLE_FILL = {BUF_BYTES{IDLE_CODE}};
    localparam logic [CTRL_WIDTH-1:0] ALL_LANES = {CTRL_WIDTH{1'b1}};

    rx_state_e             r_state;
    logic [10:0]           r_ptr;
    logic [BUF_W-1:0]      r_buf;

    logic                  w_term_found;
    logic [2:0]            w_term_lane;
    logic                  w_bad_ctrl;
    logic                  w_start;
    logic                  w_all_idle;
    logic [11:0]           w_len;
    logic [11:0]           w_ptr_plus8;
    logic [CTRL_WIDTH-1:0] w_term_mask;

    rx_term_locator #(
        .DATA_WIDTH (DATA_WIDTH),
        .CTRL_WIDTH (CTRL_WIDTH),
        .TERM_CODE  (TERM_CODE)
    ) u_term_locator (
        .i_rx_data      (i_rx_data),
        .i_rx_ctrl      (i_rx_ctrl),
        .term_found     (w_term_found),
        .term_lane      (w_term_lane),
        .bad_ctrl_found (w_bad_ctrl)
    );

    // Writes the enabled lanes of one word into the buffer starting at byte base;
    // lanes that would land past the end are dropped.
    function automatic logic [BUF_W-1:0] merge_word(
        input logic [BUF_W-1:0]      buf_in,
        input logic [11:0]           base,
        input logic [CTRL_WIDTH-1:0] lane_wr,
        input logic [DATA_WIDTH-1:0] data
    );
        logic [BUF_W-1:0] buf_out;
        logic [11:0]      idx;
        logic [11:0]      idx_c;
        logic             in_rng;
        buf_out = buf_in;
        for (int l = 0; l < CTRL_WIDTH; l++) begin
            idx    = base + 12'(l);
            in_rng = (idx < 12'(BUF_BYTES));
            idx_c  = in_rng ? idx : 12'(BUF_BYTES - 1);
            buf_out[{idx_c, 3'b000} +: 8] = (lane_wr[l] && in_rng) ?
                data[l*8 +: 8] : buf_out[{idx_c, 3'b000} +: 8];
        end
        return buf_out;
    endfunction

    assign w_start     = i_rx_ctrl[0] && (i_rx_data[7:0] == START_CODE);
    assign w_len       = {1'b0, r_ptr} + {9'd0, w_term_lane} + 12'd1;
    assign w_ptr_plus8 = {1'b0, r_ptr} + 12'd8;
    assign w_term_mask = ALL_LANES >> (3'd7 - w_term_lane);

    // An all-idle word ends a discarded frame just like a TERM does
    always_comb begin
        w_all_idle = (i_rx_ctrl == ALL_LANES);
        for (int l = 0; l < CTRL_WIDTH; l++) begin
            w_all_idle = w_all_idle && (i_rx_data[l*8 +: 8] == IDLE_CODE);
        end
    end

    // Frame collection FSM with registered buffer, pointer and status pulses
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state          <= ST_IDLE;
            r_ptr            <= 11'd0;
            r_buf            <= '0;
            o_rx_array_data  <= '0;
            o_frame_len      <= 11'd0;
            o_data_valid     <= 1'b0;
            o_framing_error  <= 1'b0;
            o_overflow_error <= 1'b0;
        end else begin
            o_data_valid     <= 1'b0;
            o_framing_error  <= 1'b0;
            o_overflow_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_buf   <= merge_word(IDLE_FILL, 12'd0, ALL_LANES, i_rx_data);
                        r_ptr   <= 11'd8;
                        r_state <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (w_bad_ctrl) begin
                        o_framing_error <= 1'b1;
                        if (w_start) begin
                            r_buf   <= merge_word(IDLE_FILL, 12'd0, ALL_LANES, i_rx_data);
                            r_ptr   <= 11'd8;
                            r_state <= ST_COLLECT;
                        end else begin
                            r_ptr   <= 11'd0;
                            r_state <= ST_IDLE;
                        end
                    end else if (w_term_found) begin
                        // Bytes above TERM are already IDLE from the fill at START
                        if (w_len > 12'(BUF_BYTES)) begin
                            o_overflow_error <= 1'b1;
                        end else begin
                            o_rx_array_data <= merge_word(r_buf, {1'b0, r_ptr}, w_term_mask, i_rx_data);
                            o_frame_len     <= w_len[10:0];
                            o_data_valid    <= 1'b1;
                        end
                        r_ptr   <= 11'd0;
                        r_state <= ST_IDLE;
                    end else if (w_ptr_plus8 > 12'(BUF_BYTES)) begin
                        o_overflow_error <= 1'b1;
                        r_ptr            <= 11'd0;
                        r_state          <= ST_DISCARD;
                    end else begin
                        r_buf <= merge_word(r_buf, {1'b0, r_ptr}, ALL_LANES, i_rx_data);
                        r_ptr <= w_ptr_plus8[10:0];
                    end
                end
                ST_DISCARD: begin
                    if (w_term_found || w_all_idle) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_ptr   <= 11'd0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_frame_collector.sv
// Directed bench for rx_frame_collector: each task drives one scenario and
// checks outputs against hand-computed values.
module tb_rx_frame_collector;

    localparam int BUF_BYTES = 1529;

    logic                   clk = 1'b0;
    logic                   i_rst_n = 1'b1;
    logic [63:0]            i_rx_data = {8{8'h07}};
    logic [7:0]             i_rx_ctrl = 8'hFF;
    logic [BUF_BYTES*8-1:0] o_rx_array_data;
    logic                   o_data_valid;
    logic [10:0]            o_frame_len;
    logic                   o_framing_error;
    logic                   o_overflow_error;

    int checks = 0;
    int fails  = 0;
    int dv_cnt = 0;
    int fe_cnt = 0;
    int of_cnt = 0;

    rx_frame_collector dut (
        .clk              (clk),
        .i_rst_n          (i_rst_n),
        .i_rx_data        (i_rx_data),
        .i_rx_ctrl        (i_rx_ctrl),
        .o_rx_array_data  (o_rx_array_data),
        .o_data_valid     (o_data_valid),
        .o_frame_len      (o_frame_len),
        .o_framing_error  (o_framing_error),
        .o_overflow_error (o_overflow_error)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] get_byte(input int n);
        return o_rx_array_data[n*8 +: 8];
    endfunction

    function automatic int non_idle_from(input int from);
        int cnt = 0;
        for (int n = from; n < BUF_BYTES; n++) begin
            if (o_rx_array_data[n*8 +: 8] != 8'h07) cnt++;
        end
        return cnt;
    endfunction

    // Present one word for one clock, then sample just after the edge
    task automatic drive(input logic [63:0] d, input logic [7:0] c);
        i_rx_data = d;
        i_rx_ctrl = c;
        @(posedge clk);
        #1;
        dv_cnt += int'(o_data_valid);
        fe_cnt += int'(o_framing_error);
        of_cnt += int'(o_overflow_error);
    endtask

    task automatic drive_idle();
        drive({8{8'h07}}, 8'hFF);
    endtask

    task automatic drive_start();
        drive({8'hD5, {6{8'h55}}, 8'hFB}, 8'h01);
    endtask

    // Data word whose byte at frame offset n is 8'(n) + off
    task automatic drive_ramp(input int base, input logic [7:0] off);
        logic [63:0] d;
        for (int l = 0; l < 8; l++) d[l*8 +: 8] = 8'(base + l) + off;
        drive(d, 8'h00);
    endtask

    task automatic drive_term(input int base, input int k, input logic [7:0] off);
        logic [63:0] d;
        logic [7:0]  c;
        for (int l = 0; l < 8; l++) begin
            if (l < k) begin
                d[l*8 +: 8] = 8'(base + l) + off;
                c[l] = 1'b0;
            end else if (l == k) begin
                d[l*8 +: 8] = 8'hFD;
                c[l] = 1'b1;
            end else begin
                d[l*8 +: 8] = 8'h07;
                c[l] = 1'b1;
            end
        end
        drive(d, c);
    endtask

    task automatic test_reset();
        #2 i_rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++; if (o_rx_array_data !== '0) begin fails++; $display("FAIL reset_array: got nonzero expected 0"); end
        checks++; if (o_frame_len !== 11'd0) begin fails++; $display("FAIL reset_len: got %0d expected 0", o_frame_len); end
        checks++; if ({o_data_valid, o_framing_error, o_overflow_error} !== 3'b000) begin
            fails++; $display("FAIL reset_pulses: got %b expected 000", {o_data_valid, o_framing_error, o_overflow_error}); end
        i_rst_n = 1'b1;
        drive_idle();
        drive_idle();
    endtask

    task automatic test_frame_64();
        int d0 = dv_cnt;
        drive_start();
        for (int j = 1; j <= 8; j++) drive_ramp(8 * j, 8'h00);
        checks++; if (dv_cnt != d0) begin fails++; $display("FAIL f64_early_valid: got %0d expected 0", dv_cnt - d0); end
        drive_term(72, 0, 8'h00);
        checks++; if (o_data_valid !== 1'b1) begin fails++; $display("FAIL f64_valid: got %b expected 1", o_data_valid); end
        checks++; if (o_frame_len !== 11'd73) begin fails++; $display("FAIL f64_len: got %0d expected 73", o_frame_len); end
        checks++; if (get_byte(0) !== 8'hFB) begin fails++; $display("FAIL f64_byte0: got %h expected fb", get_byte(0)); end
        checks++; if (get_byte(7) !== 8'hD5) begin fails++; $display("FAIL f64_byte7: got %h expected d5", get_byte(7)); end
        checks++; if (get_byte(40) !== 8'h28) begin fails++; $display("FAIL f64_byte40: got %h expected 28", get_byte(40)); end
        checks++; if (get_byte(72) !== 8'hFD) begin fails++; $display("FAIL f64_byte72: got %h expected fd", get_byte(72)); end
        checks++; if (non_idle_from(73) != 0) begin fails++; $display("FAIL f64_fill: got %0d non-idle bytes expected 0", non_idle_from(73)); end
        drive_idle();
        checks++; if (o_data_valid !== 1'b0) begin fails++; $display("FAIL f64_valid_drop: got %b expected 0", o_data_valid); end
        checks++; if (dv_cnt - d0 != 1) begin fails++; $display("FAIL f64_pulses: got %0d expected 1", dv_cnt - d0); end
    endtask

    task automatic test_term_lane5();
        int d0 = dv_cnt;
        drive_start();
        drive_ramp(8, 8'h80);
        drive_ramp(16, 8'h80);
        drive_term(24, 5, 8'h80);
        checks++; if (o_data_valid !== 1'b1) begin fails++; $display("FAIL t5_valid: got %b expected 1", o_data_valid); end
        checks++; if (o_frame_len !== 11'd30) begin fails++; $display("FAIL t5_len: got %0d expected 30", o_frame_len); end
        checks++; if (get_byte(28) !== 8'h9C) begin fails++; $display("FAIL t5_byte28: got %h expected 9c", get_byte(28)); end
        checks++; if (get_byte(29) !== 8'hFD) begin fails++; $display("FAIL t5_byte29: got %h expected fd", get_byte(29)); end
        checks++; if (non_idle_from(30) != 0) begin fails++; $display("FAIL t5_fill: got %0d non-idle bytes expected 0", non_idle_from(30)); end
        drive_idle();
        drive_idle();
        checks++; if (dv_cnt - d0 != 1) begin fails++; $display("FAIL t5_pulses: got %0d expected 1", dv_cnt - d0); end
    endtask

    task automatic test_start_upper_lane();
        int d0 = dv_cnt;
        int f0 = fe_cnt;
        drive({24'h030201, 8'hFB, 32'h04030201}, 8'h10);
        drive_ramp(8, 8'h00);
        drive_term(16, 2, 8'h00);
        drive_idle();
        checks++; if (dv_cnt != d0) begin fails++; $display("FAIL upper_start_valid: got %0d expected 0", dv_cnt - d0); end
        checks++; if (fe_cnt != f0) begin fails++; $display("FAIL upper_start_ferr: got %0d expected 0", fe_cnt - f0); end
        checks++; if (o_frame_len !== 11'd30) begin fails++; $display("FAIL upper_start_hold: got %0d expected 30", o_frame_len); end
    endtask

    task automatic test_framing();
        int d0 = dv_cnt;
        int f0 = fe_cnt;
        drive_start();
        drive_ramp(8, 8'h00);
        drive_ramp(16, 8'h00);
        drive_ramp(24, 8'h00);
        drive_start();
        checks++; if (o_framing_error !== 1'b1) begin fails++; $display("FAIL fe_pulse: got %b expected 1", o_framing_error); end
        drive_ramp(8, 8'h30);
        checks++; if (o_framing_error !== 1'b0) begin fails++; $display("FAIL fe_drop: got %b expected 0", o_framing_error); end
        drive_term(16, 0, 8'h00);
        checks++; if (o_data_valid !== 1'b1) begin fails++; $display("FAIL fe_valid: got %b expected 1", o_data_valid); end
        checks++; if (o_frame_len !== 11'd17) begin fails++; $display("FAIL fe_len: got %0d expected 17", o_frame_len); end
        checks++; if (get_byte(8) !== 8'h38) begin fails++; $display("FAIL fe_byte8: got %h expected 38", get_byte(8)); end
        checks++; if (get_byte(16) !== 8'hFD) begin fails++; $display("FAIL fe_byte16: got %h expected fd", get_byte(16)); end
        drive_idle();
        checks++; if (fe_cnt - f0 != 1) begin fails++; $display("FAIL fe_count: got %0d expected 1", fe_cnt - f0); end
        checks++; if (dv_cnt - d0 != 1) begin fails++; $display("FAIL fe_valid_count: got %0d expected 1", dv_cnt - d0); end
    endtask

    task automatic test_overflow();
        int d0 = dv_cnt;
        int o0 = of_cnt;
        int f0 = fe_cnt;
        drive_start();
        for (int i = 1; i <= 200; i++) begin
            drive_ramp(8 * i, 8'h00);
            if (i == 191) begin
                checks++; if (o_overflow_error !== 1'b1) begin fails++; $display("FAIL ovf_pulse: got %b expected 1", o_overflow_error); end
            end
        end
        checks++; if (of_cnt - o0 != 1) begin fails++; $display("FAIL ovf_count: got %0d expected 1", of_cnt - o0); end
        checks++; if (dv_cnt != d0) begin fails++; $display("FAIL ovf_valid: got %0d expected 0", dv_cnt - d0); end
        checks++; if (fe_cnt != f0) begin fails++; $display("FAIL ovf_ferr: got %0d expected 0", fe_cnt - f0); end
        drive_idle();
        drive_start();
        drive_ramp(8, 8'h10);
        drive_term(16, 2, 8'h10);
        checks++; if (o_data_valid !== 1'b1) begin fails++; $display("FAIL ovf_recover_valid: got %b expected 1", o_data_valid); end
        checks++; if (o_frame_len !== 11'd19) begin fails++; $display("FAIL ovf_recover_len: got %0d expected 19", o_frame_len); end
        checks++; if (get_byte(17) !== 8'h21) begin fails++; $display("FAIL ovf_recover_byte17: got %h expected 21", get_byte(17)); end
        checks++; if (get_byte(18) !== 8'hFD) begin fails++; $display("FAIL ovf_recover_byte18: got %h expected fd", get_byte(18)); end
        drive_idle();
    endtask

    task automatic test_back_to_back();
        int d0 = dv_cnt;
        drive_start();
        drive_ramp(8, 8'h40);
        drive_term(16, 3, 8'h40);
        checks++; if (o_data_valid !== 1'b1) begin fails++; $display("FAIL b2b_a_valid: got %b expected 1", o_data_valid); end
        checks++; if (o_frame_len !== 11'd20) begin fails++; $display("FAIL b2b_a_len: got %0d expected 20", o_frame_len); end
        checks++; if (get_byte(18) !== 8'h52) begin fails++; $display("FAIL b2b_a_byte18: got %h expected 52", get_byte(18)); end
        checks++; if (get_byte(19) !== 8'hFD) begin fails++; $display("FAIL b2b_a_byte19: got %h expected fd", get_byte(19)); end
        drive_start();
        checks++; if (o_data_valid !== 1'b0) begin fails++; $display("FAIL b2b_gap: got %b expected 0", o_data_valid); end
        checks++; if (o_frame_len !== 11'd20) begin fails++; $display("FAIL b2b_hold: got %0d expected 20", o_frame_len); end
        drive_ramp(8, 8'hC0);
        drive_term(16, 1, 8'hC0);
        checks++; if (o_data_valid !== 1'b1) begin fails++; $display("FAIL b2b_b_valid: got %b expected 1", o_data_valid); end
        checks++; if (o_frame_len !== 11'd18) begin fails++; $display("FAIL b2b_b_len: got %0d expected 18", o_frame_len); end
        checks++; if (get_byte(16) !== 8'hD0) begin fails++; $display("FAIL b2b_b_byte16: got %h expected d0", get_byte(16)); end
        checks++; if (get_byte(17) !== 8'hFD) begin fails++; $display("FAIL b2b_b_byte17: got %h expected fd", get_byte(17)); end
        checks++; if (get_byte(19) !== 8'h07) begin fails++; $display("FAIL b2b_b_byte19: got %h expected 07", get_byte(19)); end
        drive_idle();
        checks++; if (dv_cnt - d0 != 2) begin fails++; $display("FAIL b2b_count: got %0d expected 2", dv_cnt - d0); end
    endtask

    task automatic test_mid_reset();
        int d0;
        drive_start();
        drive_ramp(8, 8'h00);
        drive_ramp(16, 8'h00);
        i_rst_n = 1'b0;
        #1;
        checks++; if (o_rx_array_data !== '0) begin fails++; $display("FAIL mr_array: got nonzero expected 0"); end
        checks++; if (o_frame_len !== 11'd0) begin fails++; $display("FAIL mr_len: got %0d expected 0", o_frame_len); end
        checks++; if ({o_data_valid, o_framing_error, o_overflow_error} !== 3'b000) begin
            fails++; $display("FAIL mr_pulses: got %b expected 000", {o_data_valid, o_framing_error, o_overflow_error}); end
        @(posedge clk);
        #1;
        i_rst_n = 1'b1;
        d0 = dv_cnt;
        drive_ramp(24, 8'h00);
        drive_term(32, 0, 8'h00);
        drive_idle();
        checks++; if (dv_cnt != d0) begin fails++; $display("FAIL mr_no_valid: got %0d expected 0", dv_cnt - d0); end
        drive_start();
        drive_term(8, 0, 8'h00);
        checks++; if (o_data_valid !== 1'b1) begin fails++; $display("FAIL mr_new_valid: got %b expected 1", o_data_valid); end
        checks++; if (o_frame_len !== 11'd9) begin fails++; $display("FAIL mr_new_len: got %0d expected 9", o_frame_len); end
        checks++; if (get_byte(8) !== 8'hFD) begin fails++; $display("FAIL mr_new_byte8: got %h expected fd", get_byte(8)); end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_frame_64();
        test_term_lane5();
        test_start_upper_lane();
        test_framing();
        test_overflow();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
